rv32_multicycle_system: RTL and testbench
=========================================

# rv32_multicycle_system

Minimal RV32I multicycle processor system: one core plus a unified word-addressed instruction/data memory, with no external bus. It is the simulation top level of the design. Programs and register contents are preloaded hierarchically by the bench, and results are checked by probing internal state. It executes OP-IMM, OP (R-type), LW and SW through a shared-ALU control FSM.

## Interface
- Parameters
  - MEM_WORDS, 1024: depth of the unified memory in 32-bit words.
- Ports
  - clk  input  1  system clock; all state updates on the rising edge.
  - reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Bench-visible internals. Hierarchy names are fixed because benches preload and probe them.
  - memory.M[]: memory word array.
  - core.RegFile.RFMem[0..31]: register file.
  - core.control_fsm.current_state: 6-bit FSM state.
  - core.fetch.pc_cur: current PC.
  - core.opcode: IR[6:0].
  - core.instruction_decode.rs1, .rd, .imm_ext: decode fields.
  - core.alu.a, .b, .out: ALU operands and result.

## Operation
- Memory
  - Word index is addr[log2(MEM_WORDS)+1:2]; addr[1:0] is ignored.
  - Reads are synchronous: data is valid the cycle after the address is presented.
  - Writes are a full word, committed on the clock edge.
  - Not reset.
- Register file
  - 32×32, two combinational read ports, one write port written on the clock edge.
  - x0 always reads 0 and writes to it are discarded.
  - Not reset, so preloaded values survive reset.
- Decode (combinational from IR)
  - Fields: rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7].
  - I-immediate: sign-extended IR[31:20].
  - S-immediate: sign-extended {IR[31:25], IR[11:7]}.
- ALU
  - 32-bit operations: add, sub, and, or, xor, slt (signed), sltu, sll, srl, sra.
  - Shift amount is b[4:0]. Overflow wraps modulo 2^32.
  - Operation selection follows funct3/funct7 per RV32I.
  - For OP-IMM, funct7[5] selects sra only when funct3 = 101.
- FSM states, with 6-bit encodings in this order from 0: FETCH, FETCH_WAIT, DECODE, EXECUTEI, EXECUTER, MEMADR, MEMREAD, MEMWB, MEMWRITE, ALUWB.
  - FETCH: present PC to memory; go to FETCH_WAIT.
  - FETCH_WAIT: latch memory data into IR on exit; go to DECODE.
  - DECODE: dispatch on opcode.
    - 0010011 → EXECUTEI.
    - 0110011 → EXECUTER.
    - 0000011 or 0100011 → MEMADR.
    - Any other opcode → FETCH, with PC+4 and no architectural writes.
  - EXECUTEI: a = x[rs1], b = imm_ext; register ALU out into ALUResult on exit; go to ALUWB.
  - EXECUTER: a = x[rs1], b = x[rs2]; register the result; go to ALUWB.
  - ALUWB: x[rd] ← ALUResult on exit; PC ← PC+4; go to FETCH.
  - MEMADR: ALUResult ← x[rs1] + imm (I-immediate for loads, S-immediate for stores).
    - Loads → MEMREAD.
    - Stores → MEMWRITE.
  - MEMREAD: present ALUResult as the address; go to MEMWB.
  - MEMWB: x[rd] ← memory data; PC ← PC+4; go to FETCH.
  - MEMWRITE: M[ALUResult] ← x[rs2]; PC ← PC+4; go to FETCH.
  - Only word loads and stores are supported; the funct3 width field is ignored.
  - Misalignment is ignored (the low address bits are dropped).

## Timing
- Reset
  - While reset = 0: current_state = FETCH, pc_cur = 0, IR = 0, ALUResult = 0. Takes effect immediately (asynchronous).
  - First fetch: FETCH is the state on the first edge after release; FETCH_WAIT follows on the next edge.
  - Reset mid-instruction aborts it. The pending rd or memory write is not performed and PC returns to 0.
- PC
  - PC changes only on the edge leaving ALUWB, MEMWB or MEMWRITE.
  - pc_cur stays constant through FETCH, FETCH_WAIT and DECODE of an instruction.
- Cycle counts: OP-IMM/OP take 5 cycles; LW 6 cycles; SW 5 cycles; an unsupported opcode takes 3 cycles.
- Visibility
  - A write from ALUWB or MEMWB is visible in RFMem from the following FETCH.
  - imm_ext and rs1/rd are valid throughout DECODE.
  - alu.a, alu.b and alu.out are valid throughout EXECUTEI/EXECUTER.

## Test plan
- ADDI sequence
  - Stimulus: preload x2 = 42, x1 = 0; M[0..2] = 0x00010093, 0x00410093, 0xFF810093; release reset.
  - States must step FETCH, FETCH_WAIT, DECODE, EXECUTEI, ALUWB, FETCH.
  - In DECODE: opcode = 0010011, rs1 = 2, rd = 1, imm_ext = 0, then 4, then 0xFFFFFFF8.
  - alu.out = 42, then 46, then 34.
  - x1 = 42, 46, 34 at the next FETCH_WAIT; pc_cur = 4, then 8.
  - x2 stays 42.
- R-type: x3 = 7, x4 = 0xFFFFFFFF.
  - add x5,x3,x4 → 6.
  - sltu x5,x3,x4 → 1; slt x5,x3,x4 → 0.
  - sra x6,x4,x3 → 0xFFFFFFFF; srl x6,x4,x3 → 0x01FFFFFF.
- x0 protection: addi x0,x2,5 → x0 reads 0 afterwards.
- Memory round trip
  - x1 = 0x100, x2 = 0xDEADBEEF.
  - sw x2,4(x1) → M[65] = 0xDEADBEEF.
  - lw x3,4(x1) → x3 = 0xDEADBEEF, and the load takes 6 cycles.
- Illegal opcode: word 0x00000000 → FETCH, FETCH_WAIT, DECODE, FETCH; pc +4; no register changes.
- Reset mid-instruction
  - Assert reset during EXECUTEI of addi x1,x2,4.
  - Required: state = FETCH and pc = 0 immediately; x1 unchanged.
  - After release, the program re-executes from address 0.

Source files
------------

// File: rtl/rv32_multicycle_system.sv
// ---------------------------------------------------------------------------
// rv32_multicycle_system
//   Minimal RV32I multicycle system: one core sharing a single unified,
//   word-addressed instruction/data memory. Supports OP-IMM, OP, LW and SW.
//   Programs and register contents are preloaded hierarchically; the
//   internal names memory.M, core.RegFile.RFMem, core.control_fsm.
//   current_state, core.fetch.pc_cur, core.opcode, core.instruction_decode.
//   {rs1,rd,imm_ext} and core.alu.{a,b,out} are kept stable for probing.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
// ---------------------------------------------------------------------------
module rv32_multicycle_system #(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic reset
);

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  rv32_core core (
    .clk         (clk),
    .reset       (reset),
    .mem_rdata_i (mem_rdata),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we)
  );

  rv32_unified_mem #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk     (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

endmodule

// ---------------------------------------------------------------------------
// rv32_unified_mem
//   Word-addressed memory with registered read (data valid one cycle after
//   the address) and full-word write on the clock edge. Not reset.
// Ports
//   clk     : clock
//   addr_i  : byte address; addr[1:0] and bits above the index are ignored
//   we_i    : write enable
//   wdata_i : write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module rv32_unified_mem #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   M [MEM_WORDS];
  logic [31:0]   rdata_q;
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  assign word_idx         = addr_i[AW+1:2];
  // Byte offset and out-of-range upper bits are deliberately dropped.
  assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (we_i) begin
      M[word_idx] <= wdata_i;
    end
    rdata_q <= M[word_idx];
  end

  assign rdata_o = rdata_q;

endmodule

// ---------------------------------------------------------------------------
// rv32_regfile
//   32x32 register file, two combinational read ports, one write port.
//   x0 reads as zero and writes to it are discarded. Not reset.
// Ports
//   clk          : clock
//   ra1_i/ra2_i  : read addresses;  rd1_o/rd2_o : read data
//   we_i, wa_i, wd_i : write enable, address, data
// ---------------------------------------------------------------------------
module rv32_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] RFMem [32];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) begin
      RFMem[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : RFMem[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : RFMem[ra2_i];

endmodule

// ---------------------------------------------------------------------------
// rv32_fetch
//   Program counter. Advances by 4 only when the FSM requests it.
// Ports
//   clk, reset   : clock, async active-low reset (PC -> 0)
//   pc_write_i   : advance PC by 4 on this edge
//   pc_o         : current PC
// ---------------------------------------------------------------------------
module rv32_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_cur;
  logic [31:0] pc_d;

  assign pc_d = pc_write_i ? (pc_cur + 32'd4) : pc_cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_cur <= 32'd0;
    end else begin
      pc_cur <= pc_d;
    end
  end

  assign pc_o = pc_cur;

endmodule

// ---------------------------------------------------------------------------
// rv32_decode
//   Combinational field extraction from IR. imm_ext carries the
//   S-immediate for stores and the I-immediate otherwise.
// Ports
//   ir_i        : instruction register
//   opcode_o, rs1_o, rs2_o, rd_o, funct3_o, funct7_5_o, imm_ext_o : fields
// ---------------------------------------------------------------------------
module rv32_decode (
  input  logic [31:0] ir_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_5_o,
  output logic [31:0] imm_ext_o
);

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  logic [31:0] imm_i;
  logic [31:0] imm_s;

  assign rs1     = ir_i[19:15];
  assign rd      = ir_i[11:7];
  assign imm_i   = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_s   = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  assign imm_ext = (ir_i[6:0] == OPC_STORE) ? imm_s : imm_i;

  assign opcode_o   = ir_i[6:0];
  assign rs1_o      = rs1;
  assign rs2_o      = ir_i[24:20];
  assign rd_o       = rd;
  assign funct3_o   = ir_i[14:12];
  assign funct7_5_o = ir_i[30];
  assign imm_ext_o  = imm_ext;

endmodule

// ---------------------------------------------------------------------------
// rv32_alu
//   32-bit shared ALU. Shift amount is b[4:0]; arithmetic wraps.
// Ports
//   a_i, b_i : operands;  op_i : operation code;  out_o : result
// ---------------------------------------------------------------------------
module rv32_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] out_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;

  assign a = a_i;
  assign b = b_i;

  always_comb begin
    out = a + b;
    case (op_i)
      ALU_ADD:  out = a + b;
      ALU_SUB:  out = a - b;
      ALU_SLL:  out = a << b[4:0];
      ALU_SLT:  out = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: out = {31'd0, (a < b)};
      ALU_XOR:  out = a ^ b;
      ALU_SRL:  out = a >> b[4:0];
      ALU_SRA:  out = $signed(a) >>> b[4:0];
      ALU_OR:   out = a | b;
      ALU_AND:  out = a & b;
      default:  out = a + b;
    endcase
  end

  assign out_o = out;

endmodule

// ---------------------------------------------------------------------------
// rv32_control_fsm
//   Multicycle control sequencer. Each output is a one-cycle strobe or mux
//   select for the state currently held.
// Ports
//   clk, reset           : clock, async active-low reset (state -> FETCH)
//   opcode_i             : IR[6:0]
//   ir_write_o           : load IR from memory read data
//   pc_write_o           : advance PC
//   alu_result_write_o   : register ALU output into ALUResult
//   reg_write_o          : write rd
//   result_from_mem_o    : rd data comes from memory (else ALUResult)
//   mem_write_o          : memory write strobe
//   adr_from_alu_o       : memory address is ALUResult (else PC)
//   alu_b_from_reg_o     : ALU b is x[rs2] (else imm_ext)
//   alu_mode_o           : 0 = add, 1 = OP-IMM decode, 2 = OP decode
// ---------------------------------------------------------------------------
module rv32_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       alu_result_write_o,
  output logic       reg_write_o,
  output logic       result_from_mem_o,
  output logic       mem_write_o,
  output logic       adr_from_alu_o,
  output logic       alu_b_from_reg_o,
  output logic [1:0] alu_mode_o
);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [5:0] {
    FETCH      = 6'd0,
    FETCH_WAIT = 6'd1,
    DECODE     = 6'd2,
    EXECUTEI   = 6'd3,
    EXECUTER   = 6'd4,
    MEMADR     = 6'd5,
    MEMREAD    = 6'd6,
    MEMWB      = 6'd7,
    MEMWRITE   = 6'd8,
    ALUWB      = 6'd9
  } state_t;

  state_t current_state;
  state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_state <= FETCH;
    end else begin
      current_state <= state_d;
    end
  end

  always_comb begin
    state_d            = FETCH;
    ir_write_o         = 1'b0;
    pc_write_o         = 1'b0;
    alu_result_write_o = 1'b0;
    reg_write_o        = 1'b0;
    result_from_mem_o  = 1'b0;
    mem_write_o        = 1'b0;
    adr_from_alu_o     = 1'b0;
    alu_b_from_reg_o   = 1'b0;
    alu_mode_o         = 2'd0;
    case (current_state)
      FETCH: begin
        state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ir_write_o = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        case (opcode_i)
          OPC_OPIMM:           state_d = EXECUTEI;
          OPC_OP:              state_d = EXECUTER;
          OPC_LOAD, OPC_STORE: state_d = MEMADR;
          default: begin
            // Unsupported opcode: skip it without any architectural write.
            pc_write_o = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      EXECUTEI: begin
        alu_mode_o         = 2'd1;
        alu_result_write_o = 1'b1;
        state_d            = ALUWB;
      end
      EXECUTER: begin
        alu_mode_o         = 2'd2;
        alu_b_from_reg_o   = 1'b1;
        alu_result_write_o = 1'b1;
        state_d            = ALUWB;
      end
      MEMADR: begin
        alu_result_write_o = 1'b1;
        state_d            = (opcode_i == OPC_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_from_alu_o = 1'b1;
        state_d        = MEMWB;
      end
      MEMWB: begin
        reg_write_o       = 1'b1;
        result_from_mem_o = 1'b1;
        pc_write_o        = 1'b1;
        state_d           = FETCH;
      end
      MEMWRITE: begin
        adr_from_alu_o = 1'b1;
        mem_write_o    = 1'b1;
        pc_write_o     = 1'b1;
        state_d        = FETCH;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        state_d     = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// ---------------------------------------------------------------------------
// rv32_core
//   Datapath: IR and ALUResult registers, PC, register file, decoder,
//   shared ALU and the control FSM.
// Ports
//   clk, reset   : clock, async active-low reset
//   mem_rdata_i  : registered memory read data
//   mem_addr_o   : memory byte address (PC or ALUResult)
//   mem_wdata_o  : store data (x[rs2])
//   mem_we_o     : memory write strobe
// ---------------------------------------------------------------------------
module rv32_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] imm_ext;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_b, alu_out;
  logic [3:0]  alu_op;
  logic [31:0] pc;
  logic [31:0] rf_wdata;

  logic       ir_write, pc_write, alu_result_write, reg_write;
  logic       result_from_mem, mem_write, adr_from_alu, alu_b_from_reg;
  logic [1:0] alu_mode;

  assign opcode = ir_q[6:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q         <= 32'd0;
      alu_result_q <= 32'd0;
    end else begin
      ir_q         <= ir_d;
      alu_result_q <= alu_result_d;
    end
  end

  assign ir_d         = ir_write ? mem_rdata_i : ir_q;
  assign alu_result_d = alu_result_write ? alu_out : alu_result_q;

  rv32_control_fsm control_fsm (
    .clk                (clk),
    .reset              (reset),
    .opcode_i           (opcode),
    .ir_write_o         (ir_write),
    .pc_write_o         (pc_write),
    .alu_result_write_o (alu_result_write),
    .reg_write_o        (reg_write),
    .result_from_mem_o  (result_from_mem),
    .mem_write_o        (mem_write),
    .adr_from_alu_o     (adr_from_alu),
    .alu_b_from_reg_o   (alu_b_from_reg),
    .alu_mode_o         (alu_mode)
  );

  rv32_fetch fetch (
    .clk        (clk),
    .reset      (reset),
    .pc_write_i (pc_write),
    .pc_o       (pc)
  );

  rv32_decode instruction_decode (
    .ir_i       (ir_q),
    .opcode_o   (),
    .rs1_o      (rs1_idx),
    .rs2_o      (rs2_idx),
    .rd_o       (rd_idx),
    .funct3_o   (funct3),
    .funct7_5_o (funct7_5),
    .imm_ext_o  (imm_ext)
  );

  assign rf_wdata = result_from_mem ? mem_rdata_i : alu_result_q;

  rv32_regfile RegFile (
    .clk   (clk),
    .ra1_i (rs1_idx),
    .ra2_i (rs2_idx),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data),
    .we_i  (reg_write),
    .wa_i  (rd_idx),
    .wd_i  (rf_wdata)
  );

  // ALU control: mode 0 forces add (address calculation). funct7[5] picks
  // sub only for OP, while it picks sra for both OP and OP-IMM shifts.
  always_comb begin
    alu_op = ALU_ADD;
    if (alu_mode != 2'd0) begin
      case (funct3)
        3'b000:  alu_op = ((alu_mode == 2'd2) && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  assign alu_b = alu_b_from_reg ? rs2_data : imm_ext;

  rv32_alu alu (
    .a_i   (rs1_data),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .out_o (alu_out)
  );

  assign mem_addr_o  = adr_from_alu ? alu_result_q : pc;
  assign mem_wdata_o = rs2_data;
  assign mem_we_o    = mem_write;

endmodule

// File: tb/tb_rv32_multicycle_system.sv
module tb_rv32_multicycle_system;

  localparam logic [5:0] S_FETCH      = 6'd0;
  localparam logic [5:0] S_FETCH_WAIT = 6'd1;
  localparam logic [5:0] S_DECODE     = 6'd2;
  localparam logic [5:0] S_EXECUTEI   = 6'd3;
  localparam logic [5:0] S_ALUWB      = 6'd9;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  logic clk;
  logic reset;

  int n_vec;
  int n_miss;

  rv32_multicycle_system #(.MEM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  st;
  logic [31:0] pc;
  assign st = dut.core.control_fsm.current_state;
  assign pc = dut.core.fetch.pc_cur;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ra;
    logic [31:0] va;
    logic [4:0]  rb;
    logic [31:0] vb;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  logic [31:0] a_imm [3];
  logic [31:0] a_res [3];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Hold reset and clear the register file for the next program.
  task automatic enter_reset();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.core.RegFile.RFMem[i] <= 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge where state is FETCH; returns at the next FETCH.
  task automatic run_to_fetch(output int cycles);
    bit done;
    cycles = 1;
    done   = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (st == S_FETCH) done = 1'b1;
      else cycles++;
    end
  endtask

  initial begin
    int cyc;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;

    vecs[0]  = '{enc_i(12'h000, 5'd2, 3'b000, 5'd1, OPI), 5'd2, 32'd42, 5'd0, 32'd0, 5'd1, 32'd42};
    vecs[1]  = '{enc_i(12'h004, 5'd2, 3'b000, 5'd1, OPI), 5'd2, 32'd42, 5'd0, 32'd0, 5'd1, 32'd46};
    vecs[2]  = '{enc_i(12'hFF8, 5'd2, 3'b000, 5'd1, OPI), 5'd2, 32'd42, 5'd0, 32'd0, 5'd1, 32'd34};
    vecs[3]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'b000, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd6};
    vecs[4]  = '{enc_r(7'h20, 5'd4, 5'd3, 3'b000, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd8};
    vecs[5]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'b011, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd1};
    vecs[6]  = '{enc_r(7'h00, 5'd4, 5'd3, 3'b010, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd0};
    vecs[7]  = '{enc_r(7'h20, 5'd3, 5'd4, 3'b101, 5'd6), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF};
    vecs[8]  = '{enc_r(7'h00, 5'd3, 5'd4, 3'b101, 5'd6), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd6, 32'h01FFFFFF};
    vecs[9]  = '{enc_r(7'h00, 5'd3, 5'd4, 3'b001, 5'd6), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd6, 32'hFFFFFF80};
    vecs[10] = '{enc_r(7'h00, 5'd4, 5'd3, 3'b100, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFF8};
    vecs[11] = '{enc_r(7'h00, 5'd4, 5'd3, 3'b110, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFF0, 5'd5, 32'hFFFFFFF7};
    vecs[12] = '{enc_r(7'h00, 5'd4, 5'd3, 3'b111, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd7};
    vecs[13] = '{enc_i(12'hFFF, 5'd3, 3'b010, 5'd5, OPI), 5'd3, 32'd7, 5'd0, 32'd0, 5'd5, 32'd0};
    vecs[14] = '{enc_i(12'hFFF, 5'd3, 3'b011, 5'd5, OPI), 5'd3, 32'd7, 5'd0, 32'd0, 5'd5, 32'd1};
    vecs[15] = '{enc_i(12'h403, 5'd4, 3'b101, 5'd6, OPI), 5'd4, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd6, 32'hFFFFFFFF};
    vecs[16] = '{enc_i(12'h003, 5'd4, 3'b101, 5'd6, OPI), 5'd4, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd6, 32'h1FFFFFFF};
    vecs[17] = '{enc_i(12'h0F0, 5'd4, 3'b100, 5'd5, OPI), 5'd4, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd5, 32'hFFFFFF0F};
    vecs[18] = '{enc_i(12'h7FF, 5'd4, 3'b111, 5'd5, OPI), 5'd4, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd5, 32'h000007FF};
    vecs[19] = '{enc_i(12'h800, 5'd3, 3'b110, 5'd5, OPI), 5'd3, 32'd7, 5'd0, 32'd0, 5'd5, 32'hFFFFF807};
    vecs[20] = '{enc_i(12'h005, 5'd2, 3'b000, 5'd0, OPI), 5'd2, 32'd42, 5'd0, 32'd0, 5'd0, 32'd0};
    vecs[21] = '{enc_i(12'h400, 5'd3, 3'b000, 5'd5, OPI), 5'd3, 32'd7, 5'd0, 32'd0, 5'd5, 32'h00000407};
    vecs[22] = '{enc_r(7'h00, 5'd4, 5'd3, 3'b000, 5'd5), 5'd3, 32'h7FFFFFFF, 5'd4, 32'd1, 5'd5, 32'h80000000};
    vecs[23] = '{enc_r(7'h00, 5'd3, 5'd4, 3'b010, 5'd5), 5'd3, 32'd7, 5'd4, 32'hFFFFFFFF, 5'd5, 32'd1};
    vecs[24] = '{enc_i(12'h01F, 5'd4, 3'b001, 5'd6, OPI), 5'd4, 32'h00000003, 5'd0, 32'd0, 5'd6, 32'h80000000};

    a_imm[0] = 32'd0;  a_imm[1] = 32'd4;  a_imm[2] = 32'hFFFFFFF8;
    a_res[0] = 32'd42; a_res[1] = 32'd46; a_res[2] = 32'd34;

    // ---------------- table-driven single instructions ----------------
    for (int v = 0; v < NV; v++) begin
      enter_reset();
      dut.core.RegFile.RFMem[vecs[v].ra] <= vecs[v].va;
      dut.core.RegFile.RFMem[vecs[v].rb] <= vecs[v].vb;
      dut.memory.M[0] <= vecs[v].instr;
      dut.memory.M[1] <= 32'd0;
      release_reset();
      chk($sformatf("vec%0d reset state", v), {26'd0, st}, {26'd0, S_FETCH});
      run_to_fetch(cyc);
      chk($sformatf("vec%0d x%0d", v, vecs[v].rd), dut.core.RegFile.RFMem[vecs[v].rd], vecs[v].exp);
      chk($sformatf("vec%0d cycles", v), cyc, 32'd5);
      chk($sformatf("vec%0d pc", v), pc, 32'd4);
      $display("vec %0d instr=%h x%0d=%h cycles=%0d", v, vecs[v].instr, vecs[v].rd,
               dut.core.RegFile.RFMem[vecs[v].rd], cyc);
    end

    // ---------------- ADDI sequence with state / decode probing ----------------
    enter_reset();
    dut.core.RegFile.RFMem[2] <= 32'd42;
    dut.memory.M[0] <= 32'h00010093;
    dut.memory.M[1] <= 32'h00410093;
    dut.memory.M[2] <= 32'hFF810093;
    dut.memory.M[3] <= 32'd0;
    #1;
    chk("addi reset pc", pc, 32'd0);
    release_reset();
    chk("addi first state", {26'd0, st}, {26'd0, S_FETCH});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("addi%0d fetch_wait", k), {26'd0, st}, {26'd0, S_FETCH_WAIT});
      chk($sformatf("addi%0d pc stable fw", k), pc, 32'(4 * k));
      @(negedge clk);
      chk($sformatf("addi%0d decode", k), {26'd0, st}, {26'd0, S_DECODE});
      chk($sformatf("addi%0d opcode", k), {25'd0, dut.core.opcode}, {25'd0, OPI});
      chk($sformatf("addi%0d rs1", k), {27'd0, dut.core.instruction_decode.rs1}, 32'd2);
      chk($sformatf("addi%0d rd", k), {27'd0, dut.core.instruction_decode.rd}, 32'd1);
      chk($sformatf("addi%0d imm", k), dut.core.instruction_decode.imm_ext, a_imm[k]);
      chk($sformatf("addi%0d pc stable dec", k), pc, 32'(4 * k));
      @(negedge clk);
      chk($sformatf("addi%0d executei", k), {26'd0, st}, {26'd0, S_EXECUTEI});
      chk($sformatf("addi%0d alu.a", k), dut.core.alu.a, 32'd42);
      chk($sformatf("addi%0d alu.b", k), dut.core.alu.b, a_imm[k]);
      chk($sformatf("addi%0d alu.out", k), dut.core.alu.out, a_res[k]);
      @(negedge clk);
      chk($sformatf("addi%0d aluwb", k), {26'd0, st}, {26'd0, S_ALUWB});
      @(negedge clk);
      chk($sformatf("addi%0d back to fetch", k), {26'd0, st}, {26'd0, S_FETCH});
      chk($sformatf("addi%0d x1", k), dut.core.RegFile.RFMem[1], a_res[k]);
      chk($sformatf("addi%0d x2", k), dut.core.RegFile.RFMem[2], 32'd42);
      chk($sformatf("addi%0d pc", k), pc, 32'(4 * (k + 1)));
      $display("addi seq %0d x1=%h pc=%h", k, dut.core.RegFile.RFMem[1], pc);
    end

    // ---------------- memory round trip ----------------
    enter_reset();
    dut.core.RegFile.RFMem[1] <= 32'h00000100;
    dut.core.RegFile.RFMem[2] <= 32'hDEADBEEF;
    dut.memory.M[63] <= 32'd0;
    dut.memory.M[65] <= 32'd0;
    dut.memory.M[0]  <= enc_s(12'h004, 5'd2, 5'd1);
    dut.memory.M[1]  <= enc_i(12'h004, 5'd1, 3'b010, 5'd3, LD);
    dut.memory.M[2]  <= enc_s(12'hFFC, 5'd2, 5'd1);
    dut.memory.M[3]  <= 32'd0;
    release_reset();
    run_to_fetch(cyc);
    chk("sw cycles", cyc, 32'd5);
    chk("sw M[65]", dut.memory.M[65], 32'hDEADBEEF);
    chk("sw pc", pc, 32'd4);
    $display("sw x2,4(x1) M[65]=%h cycles=%0d", dut.memory.M[65], cyc);
    run_to_fetch(cyc);
    chk("lw cycles", cyc, 32'd6);
    chk("lw x3", dut.core.RegFile.RFMem[3], 32'hDEADBEEF);
    chk("lw pc", pc, 32'd8);
    $display("lw x3,4(x1) x3=%h cycles=%0d", dut.core.RegFile.RFMem[3], cyc);
    run_to_fetch(cyc);
    chk("sw neg cycles", cyc, 32'd5);
    chk("sw neg M[63]", dut.memory.M[63], 32'hDEADBEEF);
    chk("sw neg pc", pc, 32'd12);
    $display("sw x2,-4(x1) M[63]=%h cycles=%0d", dut.memory.M[63], cyc);

    // ---------------- illegal opcode ----------------
    enter_reset();
    dut.core.RegFile.RFMem[1] <= 32'h00000011;
    dut.memory.M[0] <= 32'd0;
    dut.memory.M[1] <= 32'd0;
    release_reset();
    @(negedge clk);
    chk("illegal fetch_wait", {26'd0, st}, {26'd0, S_FETCH_WAIT});
    @(negedge clk);
    chk("illegal decode", {26'd0, st}, {26'd0, S_DECODE});
    chk("illegal pc in decode", pc, 32'd0);
    @(negedge clk);
    chk("illegal back to fetch", {26'd0, st}, {26'd0, S_FETCH});
    chk("illegal pc", pc, 32'd4);
    chk("illegal x1", dut.core.RegFile.RFMem[1], 32'h00000011);
    chk("illegal M[0]", dut.memory.M[0], 32'd0);
    $display("illegal 00000000 pc=%h x1=%h", pc, dut.core.RegFile.RFMem[1]);

    // ---------------- reset mid-instruction ----------------
    enter_reset();
    dut.core.RegFile.RFMem[1] <= 32'h00000055;
    dut.core.RegFile.RFMem[2] <= 32'd42;
    dut.memory.M[0] <= enc_i(12'h001, 5'd2, 3'b000, 5'd7, OPI);
    dut.memory.M[1] <= 32'h00410093;
    dut.memory.M[2] <= 32'd0;
    release_reset();
    run_to_fetch(cyc);
    chk("rst first x7", dut.core.RegFile.RFMem[7], 32'd43);
    chk("rst first pc", pc, 32'd4);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst in executei", {26'd0, st}, {26'd0, S_EXECUTEI});
    #2;
    reset = 1'b0;
    #1;
    chk("rst async state", {26'd0, st}, {26'd0, S_FETCH});
    chk("rst async pc", pc, 32'd0);
    dut.core.RegFile.RFMem[7] <= 32'd0;
    @(negedge clk);
    chk("rst x1 unchanged", dut.core.RegFile.RFMem[1], 32'h00000055);
    $display("reset mid-instr state=%0d pc=%h x1=%h", st, pc, dut.core.RegFile.RFMem[1]);
    reset = 1'b1;
    run_to_fetch(cyc);
    chk("rerun x7", dut.core.RegFile.RFMem[7], 32'd43);
    chk("rerun pc", pc, 32'd4);
    run_to_fetch(cyc);
    chk("rerun x1", dut.core.RegFile.RFMem[1], 32'd46);
    chk("rerun pc2", pc, 32'd8);
    $display("rerun x7=%h x1=%h pc=%h", dut.core.RegFile.RFMem[7], dut.core.RegFile.RFMem[1], pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
